rv_exec_unit: RTL and testbench

- Execute-stage block of the single-cycle RV32I core.
- Contains three functions:
  - 32-bit ALU.
  - Branch comparator.
  - Data-address decoder that splits a load/store between data memory and the IO bus.
- Contains a one-wait-state bus sequencer that stalls the PC for one extra cycle on every load/store.

---
 rtl/rv_exec_pkg.sv | 23 ++
 rtl/rv_alu.sv | 29 ++
 rtl/rv_exec_unit.sv | 73 +++++++
 tb/tb_rv_exec_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_exec_pkg.sv
// rv_exec_pkg: shared ALU/branch encodings and the default IO base address
package rv_exec_pkg;
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;
  localparam logic [2:0] BR_NEVER  = 3'd0;
  localparam logic [2:0] BR_EQ     = 3'd1;
  localparam logic [2:0] BR_NE     = 3'd2;
  localparam logic [2:0] BR_LT     = 3'd3;
  localparam logic [2:0] BR_GE     = 3'd4;
  localparam logic [2:0] BR_LTU    = 3'd5;
  localparam logic [2:0] BR_GEU    = 3'd6;
  localparam logic [2:0] BR_ALWAYS = 3'd7;
  localparam logic [31:0] IO_BASE_DEF = 32'h8000_0000;
endpackage

// File: rtl/rv_alu.sv
// rv_alu: combinational 32-bit RV32I ALU, unused op codes yield zero
module rv_alu
  import rv_exec_pkg::*;
(
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [3:0]  alu_op,
  output logic [31:0] alu_out
);
  logic [4:0] sh;
  assign sh = alu_b[4:0];
  always_comb begin
    alu_out = 32'd0;
    case (alu_op)
      ALU_ADD:    alu_out = alu_a + alu_b;
      ALU_SUB:    alu_out = alu_a - alu_b;
      ALU_SLL:    alu_out = alu_a << sh;
      ALU_SLT:    alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:   alu_out = {31'd0, alu_a < alu_b};
      ALU_XOR:    alu_out = alu_a ^ alu_b;
      ALU_SRL:    alu_out = alu_a >> sh;
      ALU_SRA:    alu_out = $unsigned($signed(alu_a) >>> sh);
      ALU_OR:     alu_out = alu_a | alu_b;
      ALU_AND:    alu_out = alu_a & alu_b;
      ALU_PASS_B: alu_out = alu_b;
      default:    alu_out = 32'd0;
    endcase
  end
endmodule

// File: rtl/rv_exec_unit.sv
// rv_exec_unit: execute stage with ALU, branch compare, mem/IO decode and wait-state sequencer
module rv_exec_unit
  import rv_exec_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEF,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [3:0]  alu_op,
  output logic [31:0] alu_out,
  input  logic [31:0] rs1_value,
  input  logic [31:0] rs2_value,
  input  logic [2:0]  branch_cond,
  output logic        branch,
  input  logic        data_read_en,
  input  logic        data_write_en,
  input  logic [2:0]  data_size,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_value,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [2:0]  mem_data_size,
  output logic [31:0] io_address,
  output logic [31:0] io_write_value,
  output logic        io_read_en,
  output logic        io_write_en,
  output logic [2:0]  io_data_size,
  output logic        is_io,
  output logic        bus_busy
);
  localparam logic [2:0] WAIT_N = 3'(WAIT_CYCLES);
  logic [2:0] cnt_q, cnt_d;
  logic addr_io, req, eq, lt, ltu;
  rv_alu u_alu (.alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out));
  assign eq  = rs1_value == rs2_value;
  assign lt  = $signed(rs1_value) < $signed(rs2_value);
  assign ltu = rs1_value < rs2_value;
  always_comb begin
    branch = 1'b0;
    case (branch_cond)
      BR_EQ:     branch = eq;
      BR_NE:     branch = ~eq;
      BR_LT:     branch = lt;
      BR_GE:     branch = ~lt;
      BR_LTU:    branch = ltu;
      BR_GEU:    branch = ~ltu;
      BR_ALWAYS: branch = 1'b1;
      default:   branch = 1'b0;
    endcase
  end
  assign addr_io         = alu_out >= IO_BASE;
  assign req             = data_read_en | data_write_en;
  assign is_io           = addr_io & req;
  assign mem_address     = alu_out;
  assign io_address      = alu_out;
  assign mem_write_value = rs2_value;
  assign io_write_value  = rs2_value;
  assign mem_data_size   = data_size;
  assign io_data_size    = data_size;
  // Enables are held off during the wait state so the access fires exactly once.
  assign bus_busy     = req & (cnt_q < WAIT_N);
  assign mem_read_en  = data_read_en  & ~addr_io & ~bus_busy;
  assign io_read_en   = data_read_en  &  addr_io & ~bus_busy;
  assign mem_write_en = data_write_en & ~addr_io & ~bus_busy;
  assign io_write_en  = data_write_en &  addr_io & ~bus_busy;
  always_comb cnt_d = bus_busy ? cnt_q + 3'd1 : 3'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= 3'd0;
    else        cnt_q <= cnt_d;
endmodule

// File: tb/tb_rv_exec_unit.sv
// tb_rv_exec_unit: vector tables, directed bus sequences and a randomized reference-model run
module tb_rv_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_a = '0, alu_b = '0, rs1_value = '0, rs2_value = '0;
  logic [3:0]  alu_op = '0;
  logic [2:0]  branch_cond = '0, data_size = '0;
  logic        data_read_en = 1'b0, data_write_en = 1'b0;
  logic [31:0] alu_out, mem_address, mem_write_value, io_address, io_write_value;
  logic        branch, mem_read_en, mem_write_en, io_read_en, io_write_en, is_io, bus_busy;
  logic [2:0]  mem_data_size, io_data_size;
  int checks = 0;
  int errors = 0;

  rv_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .branch_cond(branch_cond), .branch(branch),
    .data_read_en(data_read_en), .data_write_en(data_write_en), .data_size(data_size),
    .mem_address(mem_address), .mem_write_value(mem_write_value), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_data_size(mem_data_size), .io_address(io_address),
    .io_write_value(io_write_value), .io_read_en(io_read_en), .io_write_en(io_write_en),
    .io_data_size(io_data_size), .is_io(is_io), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s = int'(b[4:0]);
    if (op == 0) return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
    if (op == 1) return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
    if (op == 2) return 32'((longint'(a) * (64'd1 << s)) % 64'h1_0000_0000);
    if (op == 3) return (sa < sb) ? 32'd1 : 32'd0;
    if (op == 4) return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
    if (op == 5) return a ^ b;
    if (op == 6) return 32'(longint'(a) / (64'd1 << s));
    if (op == 7) return 32'((sa - ((sa % (64'sd1 <<< s) + (64'sd1 <<< s)) % (64'sd1 <<< s))) / (64'sd1 <<< s));
    if (op == 8) return a | b;
    if (op == 9) return a & b;
    if (op == 10) return b;
    return 32'd0;
  endfunction

  function automatic logic ref_br(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = longint'(x); uy = longint'(y);
    case (c)
      3'd1: return ux == uy;
      3'd2: return ux != uy;
      3'd3: return sx < sy;
      3'd4: return sx >= sy;
      3'd5: return ux < uy;
      3'd6: return ux >= uy;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  typedef struct { logic [3:0] op; logic [31:0] a, b, exp; string name; } alu_vec_t;
  typedef struct { logic [2:0] c; logic [31:0] x, y; logic exp; string name; } br_vec_t;
  alu_vec_t av[7];
  br_vec_t  bv[7];

  task automatic drive_req(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] sz);
    alu_op = 4'd10; alu_a = '0; alu_b = addr;
    data_read_en = rd; data_write_en = wr; rs2_value = wd; data_size = sz;
  endtask

  initial begin
    int waited;
    logic busy_e, io_e;
    av[0] = '{4'd0,  32'h7FFFFFFF, 32'h1, 32'h80000000, "add_ovf"};
    av[1] = '{4'd1,  32'h0, 32'h1, 32'hFFFFFFFF, "sub_wrap"};
    av[2] = '{4'd7,  32'h80000000, 32'h4, 32'hF8000000, "sra"};
    av[3] = '{4'd3,  32'hFFFFFFFF, 32'h1, 32'h1, "slt"};
    av[4] = '{4'd4,  32'hFFFFFFFF, 32'h1, 32'h0, "sltu"};
    av[5] = '{4'd12, 32'h12345678, 32'h9ABCDEF0, 32'h0, "op12"};
    av[6] = '{4'd6,  32'h80000000, 32'h24, 32'h08000000, "srl_mask"};
    bv[0] = '{3'd3, 32'hFFFFFFFF, 32'h1, 1'b1, "blt_neg"};
    bv[1] = '{3'd4, 32'hFFFFFFFF, 32'h1, 1'b0, "bge_neg"};
    bv[2] = '{3'd5, 32'hFFFFFFFF, 32'h1, 1'b0, "bltu"};
    bv[3] = '{3'd6, 32'hFFFFFFFF, 32'h1, 1'b1, "bgeu"};
    bv[4] = '{3'd1, 32'h5, 32'h5, 1'b1, "beq"};
    bv[5] = '{3'd0, 32'h5, 32'h5, 1'b0, "never"};
    bv[6] = '{3'd7, 32'h1, 32'h2, 1'b1, "always"};

    #2;
    chk("reset_busy_idle", {31'd0, bus_busy}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      alu_op = av[i].op; alu_a = av[i].a; alu_b = av[i].b;
      #1 chk(av[i].name, alu_out, av[i].exp);
    end
    for (int i = 0; i < 7; i++) begin
      branch_cond = bv[i].c; rs1_value = bv[i].x; rs2_value = bv[i].y;
      #1 chk(bv[i].name, {31'd0, branch}, {31'd0, bv[i].exp});
    end

    // memory load at 0x100
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'h100, 32'h0, 3'd2);
    #1 chk("ld_c0_busy", {31'd0, bus_busy}, 32'd1);
    chk("ld_c0_rd", {31'd0, mem_read_en}, 32'd0);
    @(negedge clk); #1;
    chk("ld_c1_busy", {31'd0, bus_busy}, 32'd0);
    chk("ld_c1_rd", {31'd0, mem_read_en}, 32'd1);
    chk("ld_c1_isio", {31'd0, is_io}, 32'd0);
    chk("ld_c1_addr", mem_address, 32'h100);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 32'h100, 32'h0, 3'd2);
    #1 chk("idle_busy", {31'd0, bus_busy}, 32'd0);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'h100, 32'h0, 3'd2);
    #1 chk("cnt_cleared", {31'd0, bus_busy}, 32'd1);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);

    // IO store at 0x8000_0004
    @(negedge clk);
    drive_req(1'b0, 1'b1, 32'h80000004, 32'hDEADBEEF, 3'd2);
    #1 chk("st_c0_busy", {31'd0, bus_busy}, 32'd1);
    chk("st_c0_iowr", {31'd0, io_write_en}, 32'd0);
    @(negedge clk); #1;
    chk("st_c1_iowr", {31'd0, io_write_en}, 32'd1);
    chk("st_c1_wdata", io_write_value, 32'hDEADBEEF);
    chk("st_c1_size", {29'd0, io_data_size}, 32'd2);
    chk("st_c1_memwr", {31'd0, mem_write_en}, 32'd0);
    chk("st_c1_isio", {31'd0, is_io}, 32'd1);
    chk("st_c1_ioaddr", io_address, 32'h80000004);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);

    // back-to-back loads: busy 1,0,1
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'h200, 32'h0, 3'd2);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("b2b_%0d", i), {31'd0, bus_busy}, (i == 1) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);

    // asynchronous reset while the counter sits at one
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'h300, 32'h0, 3'd2);
    @(negedge clk); #1;
    chk("rst_pre_busy", {31'd0, bus_busy}, 32'd0);
    #1 rst_n = 1'b0;
    #1 chk("rst_async_busy", {31'd0, bus_busy}, 32'd1);
    chk("rst_async_rd", {31'd0, mem_read_en}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_resume", {31'd0, mem_read_en}, 32'd1);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    @(negedge clk);

    // randomized run against the reference model
    waited = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      alu_op = 4'($urandom_range(0, 15));
      alu_a = $urandom; alu_b = $urandom;
      if ($urandom_range(0, 3) == 0) alu_b = {27'd0, 5'($urandom)};
      rs1_value = $urandom;
      rs2_value = ($urandom_range(0, 3) == 0) ? rs1_value : $urandom;
      branch_cond = 3'($urandom);
      data_size = 3'($urandom);
      data_read_en = ($urandom_range(0, 2) == 0);
      data_write_en = ($urandom_range(0, 2) == 0);
      #1;
      chk("rnd_alu", alu_out, ref_alu(alu_op, alu_a, alu_b));
      chk("rnd_br", {31'd0, branch}, {31'd0, ref_br(branch_cond, rs1_value, rs2_value)});
      busy_e = (data_read_en || data_write_en) && waited < 1;
      io_e = ref_alu(alu_op, alu_a, alu_b) >= 32'h80000000;
      chk("rnd_busy", {31'd0, bus_busy}, {31'd0, busy_e});
      chk("rnd_isio", {31'd0, is_io}, {31'd0, io_e && (data_read_en || data_write_en)});
      chk("rnd_en", {28'd0, mem_read_en, io_read_en, mem_write_en, io_write_en},
          {28'd0, data_read_en && !io_e && !busy_e, data_read_en && io_e && !busy_e,
                  data_write_en && !io_e && !busy_e, data_write_en && io_e && !busy_e});
      chk("rnd_pass", {mem_address ^ io_address ^ alu_out}, ref_alu(alu_op, alu_a, alu_b));
      chk("rnd_wdata", mem_write_value & io_write_value, rs2_value);
      chk("rnd_size", {26'd0, mem_data_size, io_data_size}, {26'd0, data_size, data_size});
      waited = busy_e ? waited + 1 : 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
